// File: rtl/ex9_sel_sequencer.sv
// Select sequencer for the EX_9 6:1 priority mux: walks g through a..e, then back to f,
// holding each program step for DWELL cycles under a start/busy/done handshake.
module ex9_sel_sequencer #(
  parameter int DWELL = 8,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       loop,
  input  logic       stop,
  input  logic       hold,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel4,
  output logic       sel5,
  output logic [2:0] step,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST_CNT  = CW'(DWELL - 1);
  localparam logic [2:0]    LAST_STEP = 3'd4;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    step_reg;
  logic [4:0]    sels_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          loop_reg;

  logic [2:0]    step_next;

  // Step 1 is deliberately two-hot so EX_9's sel2-over-sel3 priority gets exercised.
  function automatic logic [4:0] pattern(input logic [2:0] s);
    case (s)
      3'd0:    pattern = 5'b10000;
      3'd1:    pattern = 5'b01100;
      3'd2:    pattern = 5'b01000;
      3'd3:    pattern = 5'b00010;
      3'd4:    pattern = 5'b00001;
      default: pattern = 5'b00000;
    endcase
  endfunction

  assign step_next = step_reg + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      step_reg  <= '0;
      sels_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      loop_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            step_reg  <= 3'd0;
            sels_reg  <= pattern(3'd0);
            busy_reg  <= 1'b1;
            loop_reg  <= loop;
          end
        end

        RUN: begin
          // stop outranks both hold and a pending step advance.
          if (stop) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            step_reg  <= '0;
            sels_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (!hold) begin
            if (cnt_reg == LAST_CNT) begin
              cnt_reg <= '0;
              if (step_reg != LAST_STEP) begin
                step_reg <= step_next;
                sels_reg <= pattern(step_next);
              end else if (loop_reg) begin
                step_reg <= 3'd0;
                sels_reg <= pattern(3'd0);
              end else begin
                state_reg <= DONE;
                step_reg  <= '0;
                sels_reg  <= '0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          step_reg  <= '0;
          sels_reg  <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign {sel1, sel2, sel3, sel4, sel5} = sels_reg;
  assign step = step_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_ex9_sel_sequencer.sv
// Directed bench: three sequencers (DWELL 4, 2, 1) share stimulus; each vector names the
// instance whose registered outputs it expects one edge after its inputs are applied.
module tb_ex9_sel_sequencer;

  logic clk = 1'b0;
  logic rst, start, loop, stop, hold;

  logic [4:0] s4, s2, s1;
  logic [2:0] st4, st2, st1;
  logic       b4, b2, b1, d4, d2, d1;

  always #5 clk = ~clk;

  ex9_sel_sequencer #(.DWELL(4), .CW(16)) u4 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .stop(stop), .hold(hold),
    .sel1(s4[4]), .sel2(s4[3]), .sel3(s4[2]), .sel4(s4[1]), .sel5(s4[0]),
    .step(st4), .busy(b4), .done(d4));

  ex9_sel_sequencer #(.DWELL(2), .CW(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .stop(stop), .hold(hold),
    .sel1(s2[4]), .sel2(s2[3]), .sel3(s2[2]), .sel4(s2[1]), .sel5(s2[0]),
    .step(st2), .busy(b2), .done(d2));

  ex9_sel_sequencer #(.DWELL(1), .CW(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .stop(stop), .hold(hold),
    .sel1(s1[4]), .sel2(s1[3]), .sel3(s1[2]), .sel4(s1[1]), .sel5(s1[0]),
    .step(st1), .busy(b1), .done(d1));

  typedef struct {
    int         dut;
    logic       start, stop, hold, loop;
    logic [4:0] sels;
    logic [2:0] step;
    logic       busy, done;
  } vec_t;

  vec_t       vq[$];
  logic [4:0] pat [0:4];
  int         nvec = 0;
  int         nerr = 0;
  string      scen;

  function automatic logic [9:0] obs(int d);
    case (d)
      4:       obs = {s4, st4, b4, d4};
      2:       obs = {s2, st2, b2, d2};
      default: obs = {s1, st1, b1, d1};
    endcase
  endfunction

  task automatic chk(string nm, int d, logic [9:0] exp);
    logic [9:0] got;
    got = obs(d);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got sels=%b step=%0d busy=%b done=%b, expected sels=%b step=%0d busy=%b done=%b",
               nm, d, got[9:5], got[4:2], got[1], got[0], exp[9:5], exp[4:2], exp[1], exp[0]);
    end else begin
      $display("ok   %s dut%0d: sels=%b step=%0d busy=%b done=%b", nm, d, got[9:5], got[4:2], got[1], got[0]);
    end
  endtask

  task automatic add(int d, logic st, logic sp, logic hd, logic lp,
                     logic [4:0] s, logic [2:0] stp, logic b, logic dn);
    vec_t v;
    v.dut = d; v.start = st; v.stop = sp; v.hold = hd; v.loop = lp;
    v.sels = s; v.step = stp; v.busy = b; v.done = dn;
    vq.push_back(v);
  endtask

  task automatic add_step(int d, int s, int n, logic st);
    for (int k = 0; k < n; k++) add(d, st, 1'b0, 1'b0, 1'b0, pat[s], 3'(s), 1'b1, 1'b0);
  endtask

  task automatic add_done(int d, logic st);
    add(d, st, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic add_idle(int d, logic st);
    add(d, st, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic run_vectors();
    string nm;
    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].start; stop = vq[i].stop; hold = vq[i].hold; loop = vq[i].loop;
      @(posedge clk);
      #1;
      nm = $sformatf("%s[%0d]", scen, i);
      chk(nm, vq[i].dut, {vq[i].sels, vq[i].step, vq[i].busy, vq[i].done});
    end
    vq.delete();
    start = 1'b0; stop = 1'b0; hold = 1'b0; loop = 1'b0;
  endtask

  // Called 1 time unit after an edge; pulses reset well clear of the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
  endtask

  initial begin
    pat[0] = 5'b10000; pat[1] = 5'b01100; pat[2] = 5'b01000;
    pat[3] = 5'b00010; pat[4] = 5'b00001;
    rst = 1'b1; start = 1'b0; loop = 1'b0; stop = 1'b0; hold = 1'b0;

    #3;
    chk("reset", 4, 10'b0);
    chk("reset", 2, 10'b0);
    chk("reset", 1, 10'b0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Single pass, DWELL 4; a start pulse mid-step 2 must be ignored.
    scen = "pass";
    add(4, 1, 0, 0, 0, pat[0], 3'd0, 1, 0);
    add_step(4, 0, 3, 0);
    add_step(4, 1, 4, 0);
    add_step(4, 2, 1, 0);
    add(4, 1, 0, 0, 0, pat[2], 3'd2, 1, 0);
    add_step(4, 2, 2, 0);
    add_step(4, 3, 4, 0);
    add_step(4, 4, 4, 0);
    add_done(4, 0);
    add_idle(4, 0);
    run_vectors();
    do_reset();

    // Looping, DWELL 2: loop is latched at start only; wrap without done, then stop in step 2.
    scen = "loop";
    add(2, 1, 0, 0, 1, pat[0], 3'd0, 1, 0);
    add_step(2, 0, 1, 0);
    for (int s = 1; s < 5; s++) add_step(2, s, 2, 0);
    add_step(2, 0, 2, 0);
    add_step(2, 1, 2, 0);
    add_step(2, 2, 1, 0);
    add(2, 0, 1, 0, 0, 5'b00000, 3'd0, 0, 1);
    add_idle(2, 0);
    run_vectors();
    do_reset();

    // Hold for 3 cycles starting at the second cycle of step 1: step 1 lasts 7 cycles.
    scen = "hold";
    add(4, 1, 0, 0, 0, pat[0], 3'd0, 1, 0);
    add_step(4, 0, 3, 0);
    add_step(4, 1, 2, 0);
    for (int k = 0; k < 3; k++) add(4, 0, 0, 1, 0, pat[1], 3'd1, 1, 0);
    add_step(4, 1, 2, 0);
    for (int s = 2; s < 5; s++) add_step(4, s, 4, 0);
    add_done(4, 0);
    add_idle(4, 0);
    run_vectors();
    do_reset();

    // start+stop together in IDLE starts; stop+hold together in RUN ends the pass.
    scen = "stophold";
    add(4, 1, 1, 0, 0, pat[0], 3'd0, 1, 0);
    add_step(4, 0, 1, 0);
    add(4, 0, 1, 1, 0, 5'b00000, 3'd0, 0, 1);
    add_idle(4, 0);
    run_vectors();
    do_reset();

    // start held high: pass, done, one IDLE cycle, then an automatic restart.
    scen = "starthigh";
    add(4, 1, 0, 0, 0, pat[0], 3'd0, 1, 0);
    add_step(4, 0, 3, 1);
    for (int s = 1; s < 5; s++) add_step(4, s, 4, 1);
    add_done(4, 1);
    add_idle(4, 1);
    add(4, 1, 0, 0, 0, pat[0], 3'd0, 1, 0);
    add_step(4, 0, 1, 0);
    run_vectors();
    do_reset();

    // DWELL 1: one cycle per step, done on the 6th cycle after start.
    scen = "dwell1";
    add(1, 1, 0, 0, 0, pat[0], 3'd0, 1, 0);
    for (int s = 1; s < 5; s++) add_step(1, s, 1, 0);
    add_done(1, 0);
    add_idle(1, 0);
    run_vectors();
    do_reset();

    // Asynchronous reset in the middle of step 3, then a clean restart.
    scen = "asyncrst";
    add(4, 1, 0, 0, 0, pat[0], 3'd0, 1, 0);
    add_step(4, 0, 3, 0);
    add_step(4, 1, 4, 0);
    add_step(4, 2, 4, 0);
    add_step(4, 3, 2, 0);
    run_vectors();
    #2 rst = 1'b1;
    #1 chk("asyncrst_immediate", 4, 10'b0);
    @(posedge clk); #1;
    chk("asyncrst_no_done", 4, 10'b0);
    #3 rst = 1'b0;
    scen = "afterrst";
    add(4, 1, 0, 0, 0, pat[0], 3'd0, 1, 0);
    add_step(4, 0, 3, 0);
    add_step(4, 1, 1, 0);
    run_vectors();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
